prescaled_updown_counter: RTL



---
 rtl/counter_pkg.sv | 11 +
 rtl/prescaler.sv | 40 ++++
 rtl/prescaled_updown_counter.sv | 80 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the prescaled counter family.
package counter_pkg;

    typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

    // Prescaler counter width: enough bits for 0..DIV-1, never below one bit.
    function automatic int prescale_width(input int div);
        return ($clog2(div) < 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/prescaler.sv
// Clock-enable prescaler: one-cycle tick every DIV enabled cycles.
module prescaler
    import counter_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = prescale_width(DIV);
    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);

    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;

    // Suppressed during reset and load so a load never coincides with a step.
    assign tick = en & (pcnt_q == PCNT_MAX) & ~rst & ~clr;

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Up/down counter stepped by an internal prescaler tick, with load and wrap/saturate boundaries.
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DIV      = 10,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             tick,
    output logic             carry
);

    if (DIV < 1) begin : g_bad_div
        $error("prescaled_updown_counter: DIV must be >= 1");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("prescaled_updown_counter: WIDTH must be >= 2");
    end

    localparam cnt_mode_e        MODE      = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
    localparam logic [WIDTH-1:0] VALUE_MAX = '1;

    logic [WIDTH-1:0] value_q, value_d;
    logic             carry_q, carry_d;

    prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    always_comb begin
        value_d = value_q;
        carry_d = 1'b0;
        if (load) begin
            value_d = load_value;
        end else if (tick) begin
            if (updn) begin
                if (value_q == VALUE_MAX) begin
                    carry_d = 1'b1;
                    value_d = (MODE == CNT_SAT) ? VALUE_MAX : '0;
                end else begin
                    value_d = value_q + WIDTH'(1);
                end
            end else begin
                if (value_q == '0) begin
                    carry_d = 1'b1;
                    value_d = (MODE == CNT_SAT) ? '0 : VALUE_MAX;
                end else begin
                    value_d = value_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            carry_q <= 1'b0;
        end else begin
            value_q <= value_d;
            carry_q <= carry_d;
        end
    end

    assign value = value_q;
    assign carry = carry_q;

endmodule
